nes_joypad_i2c_target: RTL and testbench
========================================

# nes_joypad_i2c_target

I2C target that models the far end of the NES controller bridge link: it answers an I2C controller's read transactions with the current 8-bit joypad state and accepts single-byte writes. It sits on the board-model side of the bus, so the controller-side bridge can be exercised end to end in simulation. It can also serve as a synthesizable target in a second FPGA. It samples open-drain SCL/SDA with the system clock and drives SDA through an output-enable only.

## Interface
- `ADDR`, 7'h52 — 7-bit target address matched after START.
- `SYNC_STAGES`, 2 — synchronizer depth on `scl`/`sda_in`; must be ≥2.
- `clk` input 1 — system clock; all logic on its rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `scl` input 1 — bus clock as seen on the wire.
- `sda_in` input 1 — bus data as seen on the wire.
- `sda_oe` output 1 — 1 pulls SDA low; 0 releases the line.
- `joypad_state` input 8 — live button bits, bit 7 = A … bit 0 = Right.
- `rd_strobe` output 1 — one-cycle pulse when a byte is latched for transmission.
- `wdata` output 8 — last byte written by the controller.
- `wvalid` output 1 — one-cycle pulse when `wdata` is updated.
- `busy` output 1 — high from START to STOP.

## Operation
- Front end: each line passes through `SYNC_STAGES` flops. Edges are detected against the previous synchronized value.
  - START: synchronized SDA falls while synchronized SCL is high.
  - STOP: synchronized SDA rises while synchronized SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, TX, TX_ACK, RX, RX_ACK, IGNORE.
- A START from any state, including a repeated START, clears the bit counter and goes to ADDR.
- A STOP from any state goes to IDLE and releases `sda_oe`.
- ADDR: shifts 8 bits MSB-first, sampled on SCL rising edges.
  - On the 8th bit, if bits[7:1]==ADDR, go to ADDR_ACK. Otherwise go to IGNORE.
  - If R/W=1, latch `joypad_state` into the TX shift register and pulse `rd_strobe` on the same cycle.
- ADDR_ACK: drive `sda_oe`=1 from the SCL falling edge after bit 8 until the next SCL falling edge. Then go to TX if R/W=1, else RX.
- TX: present the MSB on `sda_oe` (`sda_oe` = ~bit) at each SCL falling edge, 8 bits. After the 8th falling edge, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on SCL rising.
  - ACK (0): re-latch `joypad_state`, pulse `rd_strobe`, return to TX on the next falling edge.
  - NACK (1): go to IGNORE.
- RX: shift 8 bits on SCL rising. After the 8th bit, load `wdata` and pulse `wvalid` on the same cycle, then go to RX_ACK.
- RX_ACK: drive ACK exactly as in ADDR_ACK, then return to RX.
- IGNORE: `sda_oe`=0; wait for START or STOP.
- `busy` = state≠IDLE.

## Timing
- Reset values: `sda_oe`=0, `rd_strobe`=0, `wvalid`=0, `wdata`=8'h00, `busy`=0, state IDLE.
- A reset mid-transaction releases SDA on the next `clk` edge. The target then ignores the bus until the next START.
- Input latency: a bus edge is acted on `SYNC_STAGES`+1 `clk` cycles after it occurs on the wire. `sda_oe` changes 1 cycle after the detected SCL falling edge.
- Operating range:
  - SCL high and low phases must each be ≥ `SYNC_STAGES`+3 `clk` cycles.
  - The controller's SDA setup/hold relative to SCL must exceed the same margin.
  - Behaviour outside this range is undefined.
- Simultaneous events: a START/STOP detected in the same cycle as an SCL edge has priority over the SCL edge.
- `joypad_state` is sampled only on the latch cycles. Changes mid-byte do not affect the byte being shifted.
- No clock stretching: SCL is never driven.

## Configuration
- `NES_TARGET_GLITCH_FILTER_EN`:
  - Defined: a 3-sample majority filter follows the synchronizers on both lines. This suppresses single-cycle glitches and adds 2 cycles to the input latency. The minimum phase length rises to `SYNC_STAGES`+5 cycles.
  - Undefined: the synchronizer output is used directly.

## Test plan
- Read, address match: START, 0xA5 (7'h52, R), `joypad_state`=8'h81, controller NACKs after the byte, STOP.
  - Required: ACK low on the 9th clock.
  - Required: bits 1,0,0,0,0,0,0,1 on SDA.
  - Required: one `rd_strobe` pulse.
  - Required: `busy` falls after STOP.
- Address mismatch: 0xA7 (7'h53, R).
  - Required: `sda_oe` stays 0 for the whole transaction.
  - Required: no `rd_strobe`.
  - Required: state returns to IDLE on STOP.
- Multi-byte read: controller ACKs the first byte, with `joypad_state` changing 8'h0F→8'hF0 during byte 1.
  - Required: byte 1 = 0x0F.
  - Required: byte 2 = 0xF0.
  - Required: two `rd_strobe` pulses.
- Write: 0xA4, then 0x3C, STOP.
  - Required: `wdata`=8'h3C with one `wvalid` pulse.
  - Required: ACK on both the address and the data byte.
- Repeated START: write 0xA4 then repeated START with 0xA5.
  - Required: the target re-enters ADDR and ACKs the read.
  - Required: it transmits the current joypad byte.
- Reset mid-TX: assert `rst` while bit 3 is being driven low.
  - Required: `sda_oe`=0 the next cycle.
  - Required: no response until a new START.

Source files
------------

// File: rtl/nes_joypad_i2c_target.sv
// nes_joypad_i2c_target: I2C target answering reads with the joypad state
// and accepting single-byte writes. SCL/SDA are sampled with clk; SDA is
// driven only through an output enable (sda_oe=1 pulls the line low).
// Optional build macro: NES_TARGET_GLITCH_FILTER_EN adds a 3-sample
// majority filter behind the synchronizers on both lines.
module nes_joypad_i2c_target #(
   parameter logic [6:0] ADDR        = 7'h52,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] joypad_state,
   output logic       rd_strobe,
   output logic [7:0] wdata,
   output logic       wvalid,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_TX, S_TX_ACK, S_RX, S_RX_ACK, S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   w_scl_sync, w_sda_sync;
   logic                   w_scl, w_sda;
   logic                   r_scl_prev, r_sda_prev;
   logic                   w_start, w_stop, w_scl_rise, w_scl_fall;

   state_t     r_state;
   logic [3:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic [7:0] r_tx;
   logic       r_rw;
   logic       r_ack_flag;   // ACK states: ACK driven; TX_ACK: controller ACKed
   logic       r_sda_oe;
   logic       r_rd_strobe;
   logic       r_wvalid;
   logic [7:0] r_wdata;

   // Multi-flop synchronizers; idle bus level is high on both lines
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

   assign w_scl_sync = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_sync = r_sda_sync[SYNC_STAGES-1];

`ifdef NES_TARGET_GLITCH_FILTER_EN
   logic [1:0] r_scl_hist, r_sda_hist;
   logic       r_scl_filt, r_sda_filt;

   // Majority of the current and two previous samples, registered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_hist <= 2'b11;
         r_sda_hist <= 2'b11;
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
      end else begin
         r_scl_hist <= {r_scl_hist[0], w_scl_sync};
         r_sda_hist <= {r_sda_hist[0], w_sda_sync};
         r_scl_filt <= (w_scl_sync & r_scl_hist[0]) | (w_scl_sync & r_scl_hist[1]) |
                       (r_scl_hist[0] & r_scl_hist[1]);
         r_sda_filt <= (w_sda_sync & r_sda_hist[0]) | (w_sda_sync & r_sda_hist[1]) |
                       (r_sda_hist[0] & r_sda_hist[1]);
      end
   end

   assign w_scl = r_scl_filt;
   assign w_sda = r_sda_filt;
`else
   assign w_scl = w_scl_sync;
   assign w_sda = w_sda_sync;
`endif

   // Previous cleaned line values for edge and START/STOP detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_prev <= w_scl;
         r_sda_prev <= w_sda;
      end
   end

   assign w_scl_rise = w_scl & ~r_scl_prev;
   assign w_scl_fall = ~w_scl & r_scl_prev;
   assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
   assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

   // Protocol FSM; START/STOP take priority over any SCL edge in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 4'd0;
         r_shift     <= 7'd0;
         r_tx        <= 8'd0;
         r_rw        <= 1'b0;
         r_ack_flag  <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_rd_strobe <= 1'b0;
         r_wvalid    <= 1'b0;
         r_wdata     <= 8'd0;
      end else begin
         r_rd_strobe <= 1'b0;
         r_wvalid    <= 1'b0;
         if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
         end else if (w_stop) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift   <= {r_shift[5:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        if (r_shift == ADDR) begin
                           r_state    <= S_ADDR_ACK;
                           r_ack_flag <= 1'b0;
                           r_rw       <= w_sda;
                           if (w_sda) begin
                              r_tx        <= joypad_state;
                              r_rd_strobe <= 1'b1;
                           end
                        end else begin
                           r_state <= S_IGNORE;
                        end
                     end
                  end
               end
               S_ADDR_ACK, S_RX_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_flag) begin
                        r_sda_oe   <= 1'b1;
                        r_ack_flag <= 1'b1;
                     end else if (r_state == S_ADDR_ACK && r_rw) begin
                        // ACK ends on the same falling edge that presents the MSB
                        r_sda_oe  <= ~r_tx[7];
                        r_tx      <= {r_tx[6:0], 1'b0};
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_TX;
                     end else begin
                        r_sda_oe  <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_RX;
                     end
                  end
               end
               S_TX: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_sda_oe   <= 1'b0;
                        r_ack_flag <= 1'b0;
                        r_state    <= S_TX_ACK;
                     end else begin
                        r_sda_oe  <= ~r_tx[7];
                        r_tx      <= {r_tx[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               S_TX_ACK: begin
                  if (w_scl_rise && !r_ack_flag) begin
                     if (!w_sda) begin
                        r_tx        <= joypad_state;
                        r_rd_strobe <= 1'b1;
                        r_ack_flag  <= 1'b1;
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end else if (w_scl_fall && r_ack_flag) begin
                     r_sda_oe  <= ~r_tx[7];
                     r_tx      <= {r_tx[6:0], 1'b0};
                     r_bit_cnt <= 4'd1;
                     r_state   <= S_TX;
                  end
               end
               S_RX: begin
                  if (w_scl_rise) begin
                     r_shift   <= {r_shift[5:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_wdata    <= {r_shift, w_sda};
                        r_wvalid   <= 1'b1;
                        r_ack_flag <= 1'b0;
                        r_state    <= S_RX_ACK;
                     end
                  end
               end
               S_IGNORE: r_sda_oe <= 1'b0;
               S_IDLE:   r_sda_oe <= 1'b0;
               default: begin
                  r_state  <= S_IDLE;
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda_oe    = r_sda_oe;
   assign rd_strobe = r_rd_strobe;
   assign wvalid    = r_wvalid;
   assign wdata     = r_wdata;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_nes_joypad_i2c_target.sv
// Bench for nes_joypad_i2c_target: bit-banged I2C controller on an
// open-drain bus model, table of single transactions plus hand sequences.
module tb_nes_joypad_i2c_target;

   localparam int Q = 8;    // quarter SCL period in clk cycles
   localparam int H = 16;   // SCL high phase in clk cycles

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic [7:0] joy;
   logic       sda_line;
   logic       sda_oe, rd_strobe, wvalid, busy;
   logic [7:0] wdata;

   assign sda_line = sda_m & ~sda_oe;

   nes_joypad_i2c_target dut (
      .clk          (clk),
      .rst          (rst),
      .scl          (scl),
      .sda_in       (sda_line),
      .sda_oe       (sda_oe),
      .joypad_state (joy),
      .rd_strobe    (rd_strobe),
      .wdata        (wdata),
      .wvalid       (wvalid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Output event monitor, sampled on the inactive edge
   int         n_strobe = 0;
   int         n_wvalid = 0;
   int         n_oe = 0;
   logic [7:0] last_wdata = 8'h00;
   always @(negedge clk) begin
      if (rd_strobe) n_strobe <= n_strobe + 1;
      if (wvalid) begin
         n_wvalid   <= n_wvalid + 1;
         last_wdata <= wdata;
      end
      if (sda_oe) n_oe <= n_oe + 1;
   end

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // START or repeated START (works with SCL high or low on entry)
   task automatic bus_start();
      sda_m = 1'b1; tick(Q);
      scl = 1'b1;   tick(H);
      sda_m = 1'b0; tick(H);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(Q);
      scl = 1'b1;   tick(H);
      sda_m = 1'b1; tick(H);
   endtask

   task automatic bus_wbit(input logic b);
      sda_m = b; tick(Q);
      scl = 1'b1; tick(H);
      scl = 1'b0; tick(Q);
   endtask

   task automatic bus_rbit(output logic b);
      sda_m = 1'b1; tick(Q);
      scl = 1'b1;   tick(H / 2);
      b = sda_line; tick(H / 2);
      scl = 1'b0;   tick(Q);
   endtask

   // Returns the sampled ACK bit (0 = ACK)
   task automatic bus_wbyte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) bus_wbit(d[i]);
      bus_rbit(ack);
   endtask

   task automatic bus_rbyte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bus_rbit(b);
         d[i] = b;
      end
      bus_wbit(nack);
   endtask

   typedef struct {
      logic       is_wr;
      logic [7:0] addr;
      logic [7:0] data;     // joypad value for reads, payload for writes
      logic       exp_ack;  // 0 = target ACKs the address
      int         exp_strobe;
      int         exp_wv;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic       ack, dack, b;
      logic [7:0] d, d2, e;
      int         s0, w0, o0;

      vecs[0] = '{1'b0, 8'hA5, 8'h81, 1'b0, 1, 0};
      vecs[1] = '{1'b0, 8'hA7, 8'h81, 1'b1, 0, 0};
      vecs[2] = '{1'b1, 8'hA4, 8'h3C, 1'b0, 0, 1};
      vecs[3] = '{1'b1, 8'hA6, 8'h55, 1'b1, 0, 0};
      vecs[4] = '{1'b0, 8'hA5, 8'h5A, 1'b0, 1, 0};

      rst = 1'b1; scl = 1'b1; sda_m = 1'b1; joy = 8'h00;
      tick(5);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_rd_strobe", rd_strobe, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_wdata", wdata, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick(5);

      // Table-driven single transactions
      for (int k = 0; k < 5; k++) begin
         s0 = n_strobe; w0 = n_wvalid; o0 = n_oe;
         if (!vecs[k].is_wr) joy = vecs[k].data;
         bus_start();
         bus_wbyte(vecs[k].addr, ack);
         check("addr_ack", ack, vecs[k].exp_ack);
         if (!vecs[k].is_wr) begin
            exp_q.push_back(vecs[k].exp_ack ? 8'hFF : vecs[k].data);
            bus_rbyte(d, 1'b1);
            e = exp_q.pop_front();
            check("rd_byte", d, e);
         end else begin
            if (!vecs[k].exp_ack) exp_q.push_back(vecs[k].data);
            bus_wbyte(vecs[k].data, dack);
            check("wr_data_ack", dack, vecs[k].exp_ack);
            d = vecs[k].data;
         end
         bus_stop();
         tick(10);
         check("rd_strobe_cnt", n_strobe - s0, vecs[k].exp_strobe);
         check("wvalid_cnt", n_wvalid - w0, vecs[k].exp_wv);
         if (vecs[k].is_wr && n_wvalid != w0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wdata", last_wdata, e);
         end
         if (vecs[k].exp_ack) check("oe_quiet", n_oe - o0, 0);
         check("busy_after_stop", busy, 0);
         $display("[TB] txn %0d: %s addr=%02h data=%02h ack=%0b", k,
                  vecs[k].is_wr ? "WR" : "RD", vecs[k].addr, d, ack);
      end

      // Multi-byte read with joypad change during byte 1
      s0 = n_strobe;
      joy = 8'h0F;
      bus_start();
      bus_wbyte(8'hA5, ack);
      check("mb_addr_ack", ack, 0);
      exp_q.push_back(8'h0F);
      exp_q.push_back(8'hF0);
      for (int i = 7; i >= 0; i--) begin
         if (i == 3) joy = 8'hF0;
         bus_rbit(b);
         d[i] = b;
      end
      bus_wbit(1'b0);
      bus_rbyte(d2, 1'b1);
      bus_stop();
      tick(10);
      e = exp_q.pop_front();
      check("mb_byte1", d, e);
      e = exp_q.pop_front();
      check("mb_byte2", d2, e);
      check("mb_strobes", n_strobe - s0, 2);
      $display("[TB] txn multi-read: %02h %02h", d, d2);

      // Write address followed by repeated START and a read
      s0 = n_strobe; w0 = n_wvalid;
      joy = 8'h96;
      bus_start();
      bus_wbyte(8'hA4, ack);
      check("rs_wr_addr_ack", ack, 0);
      bus_start();
      bus_wbyte(8'hA5, ack);
      check("rs_rd_addr_ack", ack, 0);
      check("rs_busy", busy, 1);
      exp_q.push_back(8'h96);
      bus_rbyte(d, 1'b1);
      bus_stop();
      tick(10);
      e = exp_q.pop_front();
      check("rs_byte", d, e);
      check("rs_strobes", n_strobe - s0, 1);
      check("rs_wvalid", n_wvalid - w0, 0);
      $display("[TB] txn repeated-start read: %02h", d);

      // Reset while bit 3 of a TX byte is pulling SDA low
      joy = 8'h00;
      bus_start();
      bus_wbyte(8'hA5, ack);
      check("rt_addr_ack", ack, 0);
      for (int i = 0; i < 4; i++) bus_rbit(b);
      check("rt_oe_bit3", sda_oe, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rt_oe_after_rst", sda_oe, 0);
      s0 = n_strobe; o0 = n_oe;
      for (int i = 0; i < 3; i++) bus_rbit(b);
      bus_wbit(1'b0);
      for (int i = 0; i < 9; i++) bus_wbit(1'b0);
      bus_stop();
      tick(10);
      check("rt_no_oe", n_oe - o0, 0);
      check("rt_no_strobe", n_strobe - s0, 0);
      check("rt_busy", busy, 0);
      joy = 8'h3C;
      bus_start();
      bus_wbyte(8'hA5, ack);
      check("rt_new_ack", ack, 0);
      exp_q.push_back(8'h3C);
      bus_rbyte(d, 1'b1);
      bus_stop();
      tick(10);
      e = exp_q.pop_front();
      check("rt_new_byte", d, e);
      $display("[TB] txn reset-mid-tx then read: %02h", d);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
